// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and byte-lane constants for the external data SRAM model.
package dmem_pkg;
   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 16;
   localparam int BYTE_W     = 8;
   localparam int LANE_LO    = 0;
   localparam int LANE_HI    = 1;
   localparam int N_LANES    = LANE_HI - LANE_LO + 1;
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: 1M x 16 external SRAM with byte-lane writes, registered reads and a tri-stated bus
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    DEPTH     = 2**ADDR_W,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CE,
  input  logic              WE,
  input  logic              OE,
  input  logic              UB,
  input  logic              LB,
  input  logic [ADDR_W-1:0] a,
  inout  wire  [DATA_W-1:0] data
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rdata_q, rdata_d, wmask;
  logic [N_LANES-1:0] lane_q, lane_d, lane_en, drive;
  logic               rvalid_q, rvalid_d, in_range, rd, wr;
  logic [IDX_W-1:0]   idx;
  assign idx      = a[IDX_W-1:0];
  assign in_range = 32'(a) < 32'(DEPTH);
  assign lane_en  = {~UB, ~LB};
  assign rd       = ~CE & WE & ~OE;
  assign wr       = ~CE & ~WE & in_range;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign wmask[i*BYTE_W +: BYTE_W] = {BYTE_W{lane_en[i]}};
    assign drive[i] = rvalid_q & rd & lane_q[i];
    assign data[i*BYTE_W +: BYTE_W] = drive[i] ? rdata_q[i*BYTE_W +: BYTE_W] : 'z;
  end
  always_ff @(posedge clk)
    if (wr) mem[idx] <= (mem[idx] & ~wmask) | (data & wmask);
  always_comb begin
    rvalid_d = rd;
    lane_d   = rd ? lane_en : lane_q;
    rdata_d  = rd ? (in_range ? mem[idx] : '0) : rdata_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdata_q  <= '0;
      lane_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      lane_q   <= lane_d;
      rvalid_q <= rvalid_d;
    end
endmodule

// File: tb/tb_dmem_sram.sv
// tb_dmem_sram: randomized and directed checks of dmem_sram against a word-array model;
// the bus is pulled high so an undriven lane reads back as 8'hFF.
module tb_dmem_sram;
   localparam int DEPTH = 256;
   logic        clk = 1'b0;
   logic        reset, ce, we, oe, ub, lb, drv_en;
   logic [19:0] addr;
   logic [15:0] drv;
   tri1  [15:0] data;
   logic [15:0] model [DEPTH];
   int          checks = 0;
   int          errors = 0;

   assign data = drv_en ? drv : 'z;

   dmem_sram #(.ADDR_W(20), .DATA_W(16), .DEPTH(DEPTH), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset), .CE(ce), .WE(we), .OE(oe),
      .UB(ub), .LB(lb), .a(addr), .data(data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_bus(input logic [19:0] ad, input logic u, input logic l);
      logic [15:0] w;
      w = (ad < 20'(DEPTH)) ? model[ad[7:0]] : 16'h0000;
      return {u ? 8'hFF : w[15:8], l ? 8'hFF : w[7:0]};
   endfunction

   task automatic idle();
      ce = 1'b1; we = 1'b1; oe = 1'b1; ub = 1'b1; lb = 1'b1; drv_en = 1'b0;
   endtask

   task automatic wr(input logic [19:0] ad, input logic [15:0] d, input logic u, input logic l, input logic c);
      ce = c; we = 1'b0; oe = 1'($urandom_range(0, 1)); ub = u; lb = l;
      addr = ad; drv = d; drv_en = 1'b1;
      @(posedge clk); #1;
      if (!c && ad < 20'(DEPTH)) begin
         if (!l) model[ad[7:0]][7:0]  = d[7:0];
         if (!u) model[ad[7:0]][15:8] = d[15:8];
      end
      idle();
   endtask

   task automatic rd_chk(input logic [19:0] ad, input logic u, input logic l, input string nm);
      logic [15:0] e;
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = u; lb = l; addr = ad; drv_en = 1'b0;
      e = exp_bus(ad, u, l);
      @(posedge clk); #1;
      addr = 20'($urandom_range(0, 511));
      ub = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (data !== e) begin
         errors++;
         $display("FAIL %s: addr=%h data=%h expected=%h", nm, ad, data, e);
      end
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b0; idle(); addr = '0; drv = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL reset_idle: data=%h expected=ffff", data); end
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL reset_held_read: data=%h expected=ffff", data); end
      idle(); reset = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL post_reset_idle: data=%h expected=ffff", data); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) wr(20'(i), 16'($urandom), 1'b0, 1'b0, 1'b0);
      rd_chk(20'd200, 1'b0, 1'b0, "fill_readback");
   endtask

   task automatic test_full_rw();
      wr(20'h00010, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      rd_chk(20'h00010, 1'b0, 1'b0, "full_rw");
   endtask

   task automatic test_byte_lanes();
      wr(20'd5, 16'h1234, 1'b0, 1'b0, 1'b0);
      wr(20'd5, 16'hAB00, 1'b0, 1'b1, 1'b0);
      rd_chk(20'd5, 1'b0, 1'b0, "lane_merge");
      rd_chk(20'd5, 1'b1, 1'b0, "lane_hi_z");
      rd_chk(20'd5, 1'b0, 1'b1, "lane_lo_z");
      wr(20'd5, 16'h0000, 1'b1, 1'b1, 1'b0);
      rd_chk(20'd5, 1'b0, 1'b0, "no_lane_write");
      rd_chk(20'd5, 1'b1, 1'b1, "no_lane_read");
      wr(20'd6, 16'h4321, 1'b0, 1'b0, 1'b1);
      rd_chk(20'd6, 1'b0, 1'b0, "ce_high_write");
   endtask

   task automatic test_out_of_range();
      wr(20'h00200, 16'h7777, 1'b0, 1'b0, 1'b0);
      rd_chk(20'h00000, 1'b0, 1'b0, "oor_no_alias");
      rd_chk(20'h00200, 1'b0, 1'b0, "oor_read_zero");
      rd_chk(20'hFFFFF, 1'b0, 1'b0, "oor_top_zero");
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) wr(20'(i), 16'(i), 1'b0, 1'b0, 1'b0);
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0; drv_en = 1'b0; addr = 20'd1;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         #1 addr = 20'(i + 1);
         @(negedge clk);
         checks++;
         if (data !== exp_bus(20'(i), 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL pipelined_%0d: data=%h expected=%h", i, data, exp_bus(20'(i), 1'b0, 1'b0));
         end
         @(posedge clk);
      end
      #1 idle();
   endtask

   task automatic test_bus_release();
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0; drv_en = 1'b0; addr = 20'd1;
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL release_we: data=%h expected=ffff", data); end
      drv = 16'h5555; drv_en = 1'b1;
      #1;
      checks++;
      if (data !== 16'h5555) begin errors++; $display("FAIL no_contention: data=%h expected=5555", data); end
      @(posedge clk); #1;
      model[1] = 16'h5555;
      idle();
      rd_chk(20'd1, 1'b0, 1'b0, "raw_5555");
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0; addr = 20'd2;
      @(posedge clk); #1;
      ce = 1'b1;
      #1;
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL release_ce: data=%h expected=ffff", data); end
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0; drv_en = 1'b0; addr = 20'h00010;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (data !== exp_bus(20'h00010, 1'b0, 1'b0)) begin
         errors++; $display("FAIL pre_reset_drive: data=%h expected=%h", data, exp_bus(20'h00010, 1'b0, 1'b0));
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL async_reset_z: data=%h expected=ffff", data); end
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (data !== 16'hFFFF) begin errors++; $display("FAIL first_read_wait: data=%h expected=ffff", data); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (data !== exp_bus(20'h00010, 1'b0, 1'b0)) begin
         errors++; $display("FAIL mem_kept_reset: data=%h expected=%h", data, exp_bus(20'h00010, 1'b0, 1'b0));
      end
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic [19:0] ad;
         ad = ($urandom_range(0, 9) == 0) ? 20'($urandom) : 20'($urandom_range(0, DEPTH - 1));
         if ($urandom_range(0, 1) == 0)
            wr(ad, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0));
         else
            rd_chk(ad, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random_read");
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_rw();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      test_bus_release();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
